// File: rtl/psys_switch_pkg.sv
// psys_switch_pkg: shared defaults, buffer states and clog2 for the parameterised switch
package psys_switch_pkg;
  localparam int DEF_DWIDTH = 1536;
  localparam int DEF_NUM_IN = 5;
  localparam int DEF_NUM_OUT = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/multicast_fork.sv
// multicast_fork: per-output done tracking; retires the head once every masked output has taken it
module multicast_fork #(
  parameter int NUM_OUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [NUM_OUT-1:0] i_mask,
  input  logic [NUM_OUT-1:0] m_tready,
  output logic [NUM_OUT-1:0] m_tvalid,
  output logic               o_pop
);
  logic [NUM_OUT-1:0] r_done;
  logic [NUM_OUT-1:0] w_hs;
  assign m_tvalid = {NUM_OUT{i_valid}} & i_mask & ~r_done;
  assign w_hs = m_tvalid & m_tready;
  assign o_pop = i_valid && (((r_done | w_hs) & i_mask) == i_mask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_done <= '0;
    else r_done <= o_pop ? '0 : (r_done | w_hs);
endmodule

// File: rtl/param_inter_switch.sv
// param_inter_switch: N-in/M-out multicast stream switch with a 2-entry beat buffer.
// Optional PSYS_SWITCH_TLAST_EN adds tlast ports and holds in_sel/out_mask for a whole packet.
module param_inter_switch import psys_switch_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_OUT-1:0]       out_mask,
  input  logic [NUM_IN*DWIDTH-1:0] s_tdata,
  input  logic [NUM_IN-1:0]        s_tvalid,
  output logic [NUM_IN-1:0]        s_tready,
`ifdef PSYS_SWITCH_TLAST_EN
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic                     m_tlast,
`endif
  output logic [DWIDTH-1:0]        m_tdata,
  output logic [NUM_OUT-1:0]       m_tvalid,
  input  logic [NUM_OUT-1:0]       m_tready,
  output logic                     busy
);
  localparam logic [SEL_W:0] W_NUM_IN = (SEL_W+1)'(NUM_IN);
  buf_state_t r_state;
  logic [DWIDTH-1:0] r_data [2];
  logic [NUM_OUT-1:0] r_mask [2];
  logic r_wr;
  logic r_rd;
  logic [SEL_W-1:0] w_sel;
  logic [NUM_OUT-1:0] w_mask;
  logic [DWIDTH-1:0] w_din;
  logic w_ok;
  logic w_push;
  logic w_pop;
  logic w_head_valid;
`ifdef PSYS_SWITCH_TLAST_EN
  logic [1:0] r_last;
  logic r_in_pkt;
  logic [SEL_W-1:0] r_psel;
  logic [NUM_OUT-1:0] r_pmask;
  logic w_lin;
  assign w_sel = r_in_pkt ? r_psel : in_sel;
  assign w_mask = r_in_pkt ? r_pmask : out_mask;
  assign m_tlast = w_head_valid & r_last[r_rd];
`else
  assign w_sel = in_sel;
  assign w_mask = out_mask;
`endif
  assign w_head_valid = r_state != EMPTY;
  assign busy = w_head_valid;
  assign m_tdata = w_head_valid ? r_data[r_rd] : '0;
  // a full buffer still accepts when the head retires in the same cycle
  assign w_ok = rst_n && ({1'b0, w_sel} < W_NUM_IN) && (|w_mask) && (r_state != FULL || w_pop);
  assign w_push = |(s_tvalid & s_tready);
  always_comb begin
    s_tready = '0;
    w_din = '0;
`ifdef PSYS_SWITCH_TLAST_EN
    w_lin = 1'b0;
`endif
    for (int i = 0; i < NUM_IN; i++)
      if (SEL_W'(i) == w_sel) begin
        s_tready[i] = w_ok;
        w_din = s_tdata[i*DWIDTH +: DWIDTH];
`ifdef PSYS_SWITCH_TLAST_EN
        w_lin = s_tlast[i];
`endif
      end
  end
  multicast_fork #(.NUM_OUT(NUM_OUT)) u_fork (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_head_valid),
    .i_mask   (r_mask[r_rd]),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .o_pop    (w_pop)
  );
  always_ff @(posedge clk)
    if (w_push) begin
      r_data[r_wr] <= w_din;
      r_mask[r_wr] <= w_mask;
`ifdef PSYS_SWITCH_TLAST_EN
      r_last[r_wr] <= w_lin;
`endif
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
`ifdef PSYS_SWITCH_TLAST_EN
      r_in_pkt <= 1'b0;
      r_psel <= '0;
      r_pmask <= '0;
`endif
    end else begin
      r_wr <= r_wr ^ w_push;
      r_rd <= r_rd ^ w_pop;
      r_state <= (w_push == w_pop) ? r_state :
                 w_push ? (r_state == EMPTY ? ONE : FULL) :
                 (r_state == FULL ? ONE : EMPTY);
`ifdef PSYS_SWITCH_TLAST_EN
      if (w_push) begin
        r_in_pkt <= !w_lin;
        r_psel <= w_sel;
        r_pmask <= w_mask;
      end
`endif
    end
endmodule

// File: tb/tb_param_inter_switch.sv
// tb_param_inter_switch: directed vector table plus hand sequences for the stream switch
module tb_param_inter_switch;
  localparam int DW = 32;
  localparam int NI = 5;
  localparam int NO = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] in_sel;
  logic [NO-1:0] out_mask;
  logic [NI*DW-1:0] s_tdata;
  logic [NI-1:0] s_tvalid;
  logic [NI-1:0] s_tready;
  logic [DW-1:0] m_tdata;
  logic [NO-1:0] m_tvalid;
  logic [NO-1:0] m_tready;
  logic busy;
`ifdef PSYS_SWITCH_TLAST_EN
  logic [NI-1:0] s_tlast;
  logic m_tlast;
`endif
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [2:0] sel;
    logic [NO-1:0] mask;
    logic [NI-1:0] valid;
    logic [NI-1:0] rdy;
    logic [NO-1:0] mtv;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  param_inter_switch #(.DWIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_sel   (in_sel),
    .out_mask (out_mask),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
`ifdef PSYS_SWITCH_TLAST_EN
    .s_tlast  (s_tlast),
    .m_tlast  (m_tlast),
`endif
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .busy     (busy)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] ed(input int ch, input int k);
    return {8'(8'hA0 + ch), 16'h0, 8'(k)};
  endfunction
  task automatic set_data(input int k);
    for (int i = 0; i < NI; i++) s_tdata[i*DW +: DW] = ed(i, k);
  endtask
  initial begin
    tbl[0] = '{3'd2, 8'h01, 5'h00, 5'b00100, 8'h00};
    tbl[1] = '{3'd0, 8'hff, 5'h00, 5'b00001, 8'h00};
    tbl[2] = '{3'd4, 8'h80, 5'h00, 5'b10000, 8'h00};
    tbl[3] = '{3'd7, 8'h01, 5'h1f, 5'b00000, 8'h00};
    tbl[4] = '{3'd5, 8'h01, 5'h1f, 5'b00000, 8'h00};
    tbl[5] = '{3'd1, 8'h00, 5'h1f, 5'b00000, 8'h00};
    tbl[6] = '{3'd3, 8'h10, 5'h1f, 5'b01000, 8'h10};
    tbl[7] = '{3'd4, 8'hc0, 5'h10, 5'b10000, 8'hc0};
    rst_n = 1'b0;
    in_sel = 3'd2;
    out_mask = 8'h01;
    s_tvalid = '1;
    m_tready = '1;
    set_data(0);
`ifdef PSYS_SWITCH_TLAST_EN
    s_tlast = '0;
`endif
    #1;
    check("rst_s_tready", 64'(s_tready), 64'h0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_m_tdata", 64'(m_tdata), 64'h0);
    s_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[v]) begin
      @(negedge clk);
      in_sel = tbl[v].sel;
      out_mask = tbl[v].mask;
      s_tvalid = tbl[v].valid;
      m_tready = '0;
      set_data(v);
      #1;
      check($sformatf("vec%0d_s_tready", v), 64'(s_tready), 64'(tbl[v].rdy));
      @(posedge clk);
      #1;
      s_tvalid = '0;
      check($sformatf("vec%0d_m_tvalid", v), 64'(m_tvalid), 64'(tbl[v].mtv));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'(|tbl[v].mtv));
      m_tready = '1;
      @(posedge clk);
      #1;
      m_tready = '0;
      check($sformatf("vec%0d_drain", v), 64'(busy), 64'h0);
    end
    @(negedge clk);
    in_sel = 3'd2;
    out_mask = 8'h01;
    m_tready = '1;
    s_tvalid = '1;
    for (int k = 0; k < 4; k++) begin
      set_data(k);
      #1;
      check($sformatf("uni%0d_s_tready", k), 64'(s_tready), 64'b00100);
      @(posedge clk);
      #1;
      check($sformatf("uni%0d_m_tvalid", k), 64'(m_tvalid), 64'h01);
      check($sformatf("uni%0d_m_tdata", k), 64'(m_tdata), 64'(ed(2, k)));
      if (k == 3) s_tvalid = '0;
    end
    @(posedge clk);
    #1;
    check("uni_empty", 64'({busy, m_tvalid}), 64'h0);
    @(negedge clk);
    in_sel = 3'd0;
    out_mask = 8'h83;
    m_tready = 8'h03;
    set_data(5);
    s_tvalid = 5'b00001;
    @(posedge clk);
    #1;
    s_tvalid = '0;
    check("mc_first_m_tvalid", 64'(m_tvalid), 64'h83);
    check("mc_first_m_tdata", 64'(m_tdata), 64'(ed(0, 5)));
    @(posedge clk);
    #1;
    check("mc_skew1_m_tvalid", 64'(m_tvalid), 64'h80);
    @(posedge clk);
    #1;
    check("mc_skew2_m_tvalid", 64'(m_tvalid), 64'h80);
    check("mc_skew2_m_tdata", 64'(m_tdata), 64'(ed(0, 5)));
    check("mc_skew2_busy", 64'(busy), 64'h1);
    @(posedge clk);
    #1;
    m_tready = 8'h83;
    @(posedge clk);
    #1;
    check("mc_retired", 64'({busy, m_tvalid}), 64'h0);
    @(negedge clk);
    out_mask = 8'h01;
    m_tready = 8'h02;
    set_data(0);
    s_tvalid = 5'b00001;
    @(posedge clk);
    #1;
    check("ctl_b0_m_tvalid", 64'(m_tvalid), 64'h01);
    out_mask = 8'h02;
    set_data(1);
    #1;
    check("ctl_one_s_tready", 64'(s_tready), 64'b00001);
    @(posedge clk);
    #1;
    check("ctl_full_m_tvalid", 64'(m_tvalid), 64'h01);
    check("ctl_full_m_tdata", 64'(m_tdata), 64'(ed(0, 0)));
    check("ctl_full_s_tready", 64'(s_tready), 64'h0);
    check("ctl_full_busy", 64'(busy), 64'h1);
    s_tvalid = '0;
    m_tready = 8'h03;
    @(posedge clk);
    #1;
    check("ctl_b1_m_tvalid", 64'(m_tvalid), 64'h02);
    check("ctl_b1_m_tdata", 64'(m_tdata), 64'(ed(0, 1)));
    @(posedge clk);
    #1;
    check("ctl_empty", 64'({busy, m_tvalid}), 64'h0);
    @(negedge clk);
    out_mask = 8'h01;
    m_tready = '0;
    s_tvalid = 5'b00001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rm_full_s_tready", 64'(s_tready), 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_m_tvalid", 64'(m_tvalid), 64'h0);
    check("rm_busy", 64'(busy), 64'h0);
    check("rm_s_tready", 64'(s_tready), 64'h0);
    check("rm_m_tdata", 64'(m_tdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = '1;
    set_data(7);
    @(posedge clk);
    #1;
    s_tvalid = '0;
    check("rm_fresh_m_tvalid", 64'(m_tvalid), 64'h01);
    check("rm_fresh_m_tdata", 64'(m_tdata), 64'(ed(0, 7)));
    @(posedge clk);
    #1;
    check("rm_drained", 64'(busy), 64'h0);
`ifdef PSYS_SWITCH_TLAST_EN
    @(negedge clk);
    in_sel = 3'd1;
    out_mask = 8'h01;
    m_tready = '1;
    s_tvalid = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      set_data(k);
      s_tlast = (k >= 2) ? 5'b00010 : 5'b00000;
      @(posedge clk);
      #1;
      check($sformatf("pkt%0d_m_tvalid", k), 64'(m_tvalid), (k == 3) ? 64'h02 : 64'h01);
      check($sformatf("pkt%0d_m_tlast", k), 64'(m_tlast), (k >= 2) ? 64'h1 : 64'h0);
      check($sformatf("pkt%0d_m_tdata", k), 64'(m_tdata), 64'(ed(1, k)));
      if (k == 0) out_mask = 8'h02;
      if (k == 3) s_tvalid = '0;
    end
    @(posedge clk);
    #1;
    check("pkt_empty", 64'(busy), 64'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
